// File: rtl/gilbert_elliott_channel.sv
// Gilbert-Elliott two-state burst-noise channel model.
// A GOOD/BAD Markov chain, driven by a 16-bit state LFSR, selects the noise scaling that is
// applied to each accepted sample. A second LFSR supplies the raw noise.
// Both LFSRs step only on accepted samples, so the output depends on the sample index and
// not on idle gaps between samples.
// Optional feature: define GE_CHANNEL_SATURATE_EN to clamp the noisy sum instead of wrapping.
module gilbert_elliott_channel #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned TH_W       = 8,
  parameter int unsigned P_GB       = 6,
  parameter int unsigned P_BB       = 52,
  parameter int unsigned GOOD_SHIFT = 12,
  parameter int unsigned BAD_SHIFT  = 6,
  parameter logic [15:0] SEED_ST    = 16'hACE1,
  parameter logic [15:0] SEED_NZ    = 16'h1D2B,
  parameter int unsigned CNT_W      = 24
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stat_clr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_bad,
  output logic [CNT_W-1:0]  bad_cnt,
  output logic [CNT_W-1:0]  trans_cnt
);

  typedef enum logic {StGood = 1'b0, StBad = 1'b1} state_t;

  localparam logic [1:0]  ModeMarkov = 2'd0;
  localparam logic [1:0]  ModeGood   = 2'd1;
  localparam logic [1:0]  ModeBad    = 2'd2;
  localparam int unsigned ThCmpW     = TH_W + 1;
  // Thresholds are held one bit wider so that 2^TH_W is representable.
  localparam logic [ThCmpW-1:0] PGbTh = ThCmpW'(P_GB);
  localparam logic [ThCmpW-1:0] PBbTh = ThCmpW'(P_BB);
  // An all-zero seed would lock the LFSR.
  localparam logic [15:0] SeedSt  = (SEED_ST == 16'd0) ? 16'd1 : SEED_ST;
  localparam logic [15:0] SeedNz  = (SEED_NZ == 16'd0) ? 16'd1 : SEED_NZ;
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [15:0]               r_lfsr_st;
  logic [15:0]               r_lfsr_nz;
  logic [15:0]               w_lfsr_st_nxt;
  logic [15:0]               w_lfsr_nz_nxt;
  logic [ThCmpW-1:0]         w_u;
  logic                      w_eff_bad;
  logic                      w_noise_en;
  logic signed [15:0]        w_nz_pre;
  logic signed [DATA_W-1:0]  w_noise_raw;
  logic signed [DATA_W-1:0]  w_noise_scaled;
  logic [DATA_W-1:0]         w_sum;
  logic                      r_out_valid;
  logic [DATA_W-1:0]         r_out_data;
  logic                      r_out_bad;
  logic [CNT_W-1:0]          r_bad_cnt;
  logic [CNT_W-1:0]          r_trans_cnt;

  // x^16+x^14+x^13+x^11+1, shifted left with feedback into bit 0.
  assign w_lfsr_st_nxt = {r_lfsr_st[14:0],
                          r_lfsr_st[15] ^ r_lfsr_st[13] ^ r_lfsr_st[12] ^ r_lfsr_st[10]};
  assign w_lfsr_nz_nxt = {r_lfsr_nz[14:0],
                          r_lfsr_nz[15] ^ r_lfsr_nz[13] ^ r_lfsr_nz[12] ^ r_lfsr_nz[10]};

  assign w_u         = {1'b0, r_lfsr_st[TH_W-1:0]};
  assign w_nz_pre    = r_lfsr_nz;
  assign w_noise_raw = DATA_W'(w_nz_pre);

  // Effective channel state for the current sample and whether noise is applied.
  always_comb begin
    w_eff_bad  = 1'b0;
    w_noise_en = 1'b1;
    case (mode)
      ModeMarkov: w_eff_bad = (r_state == StBad);
      ModeGood:   w_eff_bad = 1'b0;
      ModeBad:    w_eff_bad = 1'b1;
      default:    w_noise_en = 1'b0;
    endcase
  end

  // Noise scaling; kept as separate signed assignments so >>> stays arithmetic.
  always_comb begin
    w_noise_scaled = '0;
    if (!w_noise_en) begin
      w_noise_scaled = '0;
    end else if (w_eff_bad) begin
      w_noise_scaled = w_noise_raw >>> BAD_SHIFT;
    end else begin
      w_noise_scaled = w_noise_raw >>> GOOD_SHIFT;
    end
  end

`ifdef GE_CHANNEL_SATURATE_EN
  logic [DATA_W:0] w_sum_ext;

  // Widened sum, clamped to the most positive or most negative value on overflow.
  always_comb begin
    w_sum_ext = {in_data[DATA_W-1], in_data}
              + {w_noise_scaled[DATA_W-1], w_noise_scaled};
    w_sum     = w_sum_ext[DATA_W-1:0];
    if (w_sum_ext[DATA_W] != w_sum_ext[DATA_W-1]) begin
      w_sum = w_sum_ext[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  // Plain two's-complement wrap-around.
  always_comb begin
    w_sum = in_data + w_noise_scaled;
  end
`endif

  // Markov next state; advances on every accepted sample regardless of mode.
  always_comb begin
    w_state_nxt = r_state;
    if (in_valid) begin
      case (r_state)
        StGood:  w_state_nxt = (w_u < PGbTh) ? StBad : StGood;
        default: w_state_nxt = (w_u < PBbTh) ? StBad : StGood;
      endcase
    end
  end

  // Markov state and LFSR registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state   <= StGood;
      r_lfsr_st <= SeedSt;
      r_lfsr_nz <= SeedNz;
    end else begin
      r_state <= w_state_nxt;
      if (in_valid) begin
        r_lfsr_st <= w_lfsr_st_nxt;
        r_lfsr_nz <= w_lfsr_nz_nxt;
      end
    end
  end

  // Output register; data and state hold across idle cycles.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_bad   <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_out_data <= w_sum;
        r_out_bad  <= w_eff_bad;
      end
    end
  end

  // Saturating statistics counters; a clear overrides a same-cycle increment.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_bad_cnt   <= '0;
      r_trans_cnt <= '0;
    end else if (stat_clr) begin
      r_bad_cnt   <= '0;
      r_trans_cnt <= '0;
    end else begin
      if (in_valid && w_eff_bad && (r_bad_cnt != CntMax)) begin
        r_bad_cnt <= r_bad_cnt + CntOne;
      end
      if ((w_state_nxt != r_state) && (r_trans_cnt != CntMax)) begin
        r_trans_cnt <= r_trans_cnt + CntOne;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_bad   = r_out_bad;
  assign bad_cnt   = r_bad_cnt;
  assign trans_cnt = r_trans_cnt;

endmodule

// File: tb/tb_gilbert_elliott_channel.sv
// Scoreboard bench for gilbert_elliott_channel: the driver pushes model-predicted responses,
// a negedge monitor pops and compares them whenever out_valid is seen.
// Two extra instances cover the threshold extremes and a 4-bit counter width.
module tb_gilbert_elliott_channel;

  typedef struct packed {
    logic [15:0] data;
    logic        bad;
    logic [23:0] bcnt;
    logic [23:0] tcnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        in_valid;
  logic [15:0] in_data;
  logic        stat_clr;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_bad;
  logic [23:0] bad_cnt;
  logic [23:0] trans_cnt;

  // Shared stimulus for the threshold-extreme instances.
  logic        e_rst;
  logic        e_valid;
  logic [1:0]  e_mode;
  logic [15:0] e_data;
  logic        e_clr;
  logic        a_valid, z_valid;
  logic [15:0] a_data, z_data;
  logic        a_bad, z_bad;
  logic [3:0]  a_bcnt, a_tcnt, z_bcnt, z_tcnt;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_neg  = 0;
  logic phase_bad = 1'b0;

  exp_t        q[$];
  logic [15:0] m_st, m_nz;
  logic        m_bad;
  logic [23:0] m_bcnt, m_tcnt;

  always #5 clk = ~clk;

  gilbert_elliott_channel u_dut (
    .CLOCK_50 (clk),      .reset    (rst),      .mode     (mode),
    .in_valid (in_valid), .in_data  (in_data),  .stat_clr (stat_clr),
    .out_valid(out_valid),.out_data (out_data), .out_bad  (out_bad),
    .bad_cnt  (bad_cnt),  .trans_cnt(trans_cnt)
  );

  gilbert_elliott_channel #(.P_GB(256), .P_BB(256), .CNT_W(4)) u_abs (
    .CLOCK_50 (clk),      .reset    (e_rst),    .mode     (e_mode),
    .in_valid (e_valid),  .in_data  (e_data),   .stat_clr (e_clr),
    .out_valid(a_valid),  .out_data (a_data),   .out_bad  (a_bad),
    .bad_cnt  (a_bcnt),   .trans_cnt(a_tcnt)
  );

  gilbert_elliott_channel #(.P_GB(0), .CNT_W(4)) u_nev (
    .CLOCK_50 (clk),      .reset    (e_rst),    .mode     (e_mode),
    .in_valid (e_valid),  .in_data  (e_data),   .stat_clr (e_clr),
    .out_valid(z_valid),  .out_data (z_data),   .out_bad  (z_bad),
    .bad_cnt  (z_bcnt),   .trans_cnt(z_tcnt)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st   = 16'hACE1;
    m_nz   = 16'h1D2B;
    m_bad  = 1'b0;
    m_bcnt = '0;
    m_tcnt = '0;
    q.delete();
  endtask

  // One cycle of stimulus; the model predicts the response and queues it.
  task automatic drive(input logic v, input logic [1:0] md, input logic [15:0] d,
                       input logic clr);
    exp_t               e;
    logic               eff, nxt;
    logic signed [15:0] n, sn;
    logic [16:0]        s;
    @(negedge clk);
    in_valid = v;
    mode     = md;
    in_data  = d;
    stat_clr = clr;
    e        = '0;
    if (v) begin
      eff = (md == 2'd0) ? m_bad : (md == 2'd2);
      n   = m_nz;
      if (md == 2'd3)  sn = 16'sd0;
      else if (eff)    sn = n >>> 6;
      else             sn = n >>> 12;
      s = {d[15], d} + {sn[15], sn};
`ifdef GE_CHANNEL_SATURATE_EN
      if (s[16] != s[15]) e.data = s[16] ? 16'h8000 : 16'h7FFF;
      else                e.data = s[15:0];
`else
      e.data = s[15:0];
`endif
      nxt = m_bad ? (m_st[7:0] < 8'd52) : (m_st[7:0] < 8'd6);
      if (nxt != m_bad && m_tcnt != 24'hFFFFFF) m_tcnt++;
      if (eff && m_bcnt != 24'hFFFFFF) m_bcnt++;
      m_bad = nxt;
      m_st  = lfsr_step(m_st);
      m_nz  = lfsr_step(m_nz);
      e.bad = eff;
    end
    if (clr) begin
      m_bcnt = '0;
      m_tcnt = '0;
    end
    if (v) begin
      e.bcnt = m_bcnt;
      e.tcnt = m_tcnt;
      q.push_back(e);
    end
  endtask

  // Monitor: compares every presented output against the oldest queued prediction.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got data=%h with no prediction queued", out_data);
      end else begin
        e = q.pop_front();
        if (out_data !== e.data || out_bad !== e.bad || bad_cnt !== e.bcnt ||
            trans_cnt !== e.tcnt) begin
          n_fail++;
          $display("FAIL sample: got data=%h bad=%b bcnt=%0d tcnt=%0d, want data=%h bad=%b bcnt=%0d tcnt=%0d",
                   out_data, out_bad, bad_cnt, trans_cnt, e.data, e.bad, e.bcnt, e.tcnt);
        end
      end
      if (phase_bad && out_data[15]) n_neg++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mode = 2'd0; in_valid = 1'b0; in_data = '0; stat_clr = 1'b0;
    e_rst = 1'b1; e_valid = 1'b0; e_mode = 2'd0; e_data = '0; e_clr = 1'b0;
    model_reset();
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_bad",   32'(out_bad),   32'd0);
    check("rst_bad_cnt",   32'(bad_cnt),   32'd0);
    check("rst_trans_cnt", 32'(trans_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Bypass passes the sample through untouched.
    drive(1'b1, 2'd3, 16'h1234, 1'b0);
    drive(1'b0, 2'd3, 16'h0000, 1'b0);
    check("bypass_data", 32'(out_data), 32'h1234);
    check("bypass_bcnt", 32'(bad_cnt),  32'd0);

    // Forced GOOD, then forced BAD, then reset while a sample is in flight.
    for (int i = 0; i < 8; i++) drive(1'b1, 2'd1, 16'(i * 16'h0321), 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 2'd2, 16'(16'h1111 * i), 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    model_reset();
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data",  32'(out_data),  32'd0);
    check("mid_rst_out_bad",   32'(out_bad),   32'd0);
    check("mid_rst_bad_cnt",   32'(bad_cnt),   32'd0);
    check("mid_rst_trans_cnt", 32'(trans_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) drive(1'b1, 2'd1, 16'(16'h0F0F * i), 1'b0);

    // Forced BAD at full-scale positive input.
    drive(1'b0, 2'd2, 16'h0000, 1'b1);
    phase_bad = 1'b1;
    for (int i = 0; i < 1000; i++) drive(1'b1, 2'd2, 16'h7FFF, 1'b0);
    drive(1'b0, 2'd2, 16'h0000, 1'b0);
    check("forced_bad_cnt", 32'(bad_cnt), 32'd1000);
    drive(1'b0, 2'd2, 16'h0000, 1'b0);
    phase_bad = 1'b0;
`ifdef GE_CHANNEL_SATURATE_EN
    check("sat_no_negative", 32'(n_neg), 32'd0);
`else
    check("wrap_has_negative", 32'(n_neg > 0), 32'd1);
`endif

    // Clear on the same cycle as a BAD sample wins over the increment.
    drive(1'b1, 2'd2, 16'h0100, 1'b1);
    drive(1'b0, 2'd2, 16'h0000, 1'b0);
    check("clr_wins", 32'(bad_cnt), 32'd0);

    // Mode switches take effect on the next accepted sample.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'(i % 4), 16'(16'h8000 + i * 16'h1001), 1'b0);
      if (i % 3 == 0) drive(1'b0, 2'(i % 4), 16'hDEAD, 1'b0);
    end

    // Markov run with random idle gaps.
    drive(1'b0, 2'd0, 16'h0000, 1'b1);
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(15) == 0) drive(1'b0, 2'd0, 16'(($urandom)), 1'b0);
      drive(1'b1, 2'd0, 16'(($urandom)), 1'b0);
    end
    drive(1'b0, 2'd0, 16'h0000, 1'b0);
    check("markov_bad_cnt", 32'(bad_cnt), 32'(m_bcnt));
    check("markov_saw_bad", 32'(bad_cnt > 0), 32'd1);
    drive(1'b0, 2'd0, 16'h0000, 1'b0);
    check("queue_drained", 32'(q.size()), 32'd0);

    // Threshold extremes: absorbing BAD (P_GB=P_BB=256) and never-BAD (P_GB=0).
    @(negedge clk);
    e_rst = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("abs_out_bad", 32'(a_bad), 32'((i - 1) >= 1));
        check("nev_out_bad", 32'(z_bad), 32'd0);
      end
      e_valid = 1'b1;
    end
    @(negedge clk);
    e_valid = 1'b0;
    check("abs_out_bad_last", 32'(a_bad),  32'd1);
    check("abs_trans_cnt",    32'(a_tcnt), 32'd1);
    check("abs_bad_cnt_sat",  32'(a_bcnt), 32'd15);
    check("nev_trans_cnt",    32'(z_tcnt), 32'd0);
    check("nev_bad_cnt",      32'(z_bcnt), 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gilbert_elliott_channel.md
Name: gilbert_elliott_channel

Overview:
- Parametrised two-state (Gilbert-Elliott) burst-noise channel model. It supersedes the fixed 16-bit good/bad channel.
- Sits between the transmitter/encoder and the receiver/decoder.
- Accepts one sample per valid cycle and adds state-dependent pseudo-random noise.
- Advances a Markov GOOD/BAD state per accepted sample, with run-time mode override and statistics counters.
- Fully deterministic from seeds, so a bench reference model can reproduce it bit-exact.

Parameters:
- DATA_W, 16, sample width, two's complement.
- TH_W, 8, width of the uniform random value used for state transitions.
- P_GB, 6, GOOD->BAD threshold. Transition when u < P_GB. Range 0..2^TH_W.
- P_BB, 52, BAD stay threshold. Stay BAD when u < P_BB. Range 0..2^TH_W.
- GOOD_SHIFT, 12, arithmetic right shift applied to the raw noise in GOOD.
- BAD_SHIFT, 6, arithmetic right shift applied to the raw noise in BAD.
- SEED_ST, 16'hACE1, seed of the state LFSR. Zero is replaced by 1.
- SEED_NZ, 16'h1D2B, seed of the noise LFSR. Zero is replaced by 1.
- CNT_W, 24, width of the statistics counters.

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mode  in  2  0 = Markov, 1 = force GOOD, 2 = force BAD, 3 = bypass (no noise).
- in_valid  in  1  sample present this cycle.
- in_data  in  DATA_W  input sample.
- stat_clr  in  1  synchronous clear of the statistics counters.
- out_valid  out  1  registered in_valid.
- out_data  out  DATA_W  noisy sample.
- out_bad  out  1  channel state used for out_data (1 = BAD).
- bad_cnt  out  CNT_W  accepted samples processed in BAD.
- trans_cnt  out  CNT_W  number of GOOD<->BAD transitions of the Markov state.

Behaviour:
- Reset (asynchronous):
  - Markov state = GOOD.
  - LFSRs loaded with seeds.
  - out_valid = 0, out_data = 0, out_bad = 0, bad_cnt = 0, trans_cnt = 0.
- Reset asserted mid-stream drops any in-flight sample. No output is produced for it.
- LFSRs are 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shift left with feedback into bit 0.
  - They step only on cycles with in_valid = 1, so output depends on sample index, not idle gaps.
- The state LFSR supplies u = lfsr_st[TH_W-1:0] (pre-step value).
- Noise:
  - Raw noise n = noise LFSR pre-step value, truncated or sign-extended to DATA_W as signed.
  - Scaled noise = n >>> GOOD_SHIFT when the effective state is GOOD, n >>> BAD_SHIFT when BAD.
- Effective state for the current sample:
  - Markov mode: the current Markov state register.
  - Force modes: GOOD or BAD respectively.
  - Bypass: GOOD, with noise forced to 0.
- Markov next-state rules, updated on each accepted sample in every mode (so switching back to Markov resumes a consistent chain):
  - GOOD: go to BAD if u < P_GB, else stay GOOD.
  - BAD: stay BAD if u < P_BB, else go to GOOD.
- Output latency is 1 cycle. Each cycle:
  - out_valid <= in_valid.
  - When in_valid = 1: out_data <= in_data + scaled noise, with DATA_W wrap-around unless the optional feature is enabled.
  - When in_valid = 1: out_bad <= effective state.
  - When in_valid = 0: out_data and out_bad hold their previous values.
- bad_cnt increments on an accepted sample whose effective state is BAD. It saturates at all-ones.
- trans_cnt increments when the Markov state register changes value. It saturates at all-ones.
- stat_clr:
  - Zeroes both counters the next cycle.
  - A simultaneous increment is lost; clear wins.
- A mode change takes effect on the next accepted sample. There is no pipeline flush.
- Thresholds at the boundaries:
  - P_GB = 0: the chain never leaves GOOD.
  - P_GB = 2^TH_W: GOOD always goes to BAD.
  - P_BB = 0: BAD always returns to GOOD.
  - P_BB = 2^TH_W: BAD is absorbing.
- Threshold compare is done at TH_W+1 bits so that 2^TH_W is representable.

Optional Feature:
- Macro: GE_CHANNEL_SATURATE_EN.
- Defined: the addition is done at DATA_W+1 bits and the result is clamped.
  - Positive overflow gives 0111..1.
  - Negative overflow gives 1000..0.
- Not defined: plain DATA_W-bit two's-complement wrap-around.

Test Plan:
- Reset:
  - Stimulus: assert reset mid-stream.
  - Required: out_valid, out_data, out_bad, bad_cnt and trans_cnt go to 0 without waiting for a clock edge.
  - Required: after release, the first 8 outputs with mode = 1 match the model restarted from SEED_NZ.
- Bypass:
  - Stimulus: mode = 3, in_data = 16'h1234 for one valid cycle.
  - Required: next cycle out_valid = 1, out_data = 16'h1234, out_bad = 0, bad_cnt unchanged.
- Forced BAD with saturation:
  - Stimulus: mode = 2, in_data = 16'h7FFF, 1000 samples, GE_CHANNEL_SATURATE_EN defined.
  - Required: no out_data below the model value; every positive-noise sample gives 16'h7FFF; bad_cnt = 1000.
  - Stimulus: same run without the macro.
  - Required: model-matched wrapped values, i.e. some negative results.
- Threshold extremes:
  - Stimulus: P_GB = 0, mode = 0, 10000 samples.
  - Required: out_bad always 0, trans_cnt = 0.
  - Stimulus: P_GB = 256, P_BB = 256.
  - Required: out_bad = 0 for sample 0, 1 from sample 1 onward, trans_cnt = 1.
- Markov statistics:
  - Stimulus: default parameters, 100000 samples with random idle gaps.
  - Required: out_data and out_bad bit-exact to the model.
  - Required: bad fraction within 10% of P_GB / (P_GB + 256 - P_BB) ≈ 2.9%.
  - Required: idle gaps do not alter the sequence.
- Counters:
  - Stimulus: stat_clr asserted on the same cycle as a BAD sample.
  - Required: bad_cnt = 0 the next cycle.
  - Stimulus: CNT_W = 4 with 20 BAD samples.
  - Required: bad_cnt sticks at 15.
